// File: rtl/pio_poll_master_pkg.sv
// pio_poll_master_pkg: shared FSM encoding and Avalon constants for the PIO poller
package pio_poll_master_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_EVAL = 2'd3;
    localparam int PIO_DATA_ADDR = 0;
    localparam int RDATA_W = 32;
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: whole-vector debounce producing a stable state plus press/release pulses
module pio_debounce #(
    parameter int DATA_W = 7,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] state_o,
    output logic [DATA_W-1:0] press_o,
    output logic [DATA_W-1:0] release_o,
    output logic              valid_o
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q, last_d, state_q, state_d;
    logic              upd;

    // Pulses are driven in the strobe cycle, while the new state is being loaded
    always_comb begin
        cnt_d     = !strobe_i ? cnt_q :
                    (sample_i != last_q) ? CW'(1) :
                    (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        last_d    = strobe_i ? sample_i : last_q;
        upd       = strobe_i && (cnt_d == CNT_MAX) && (last_d != state_q);
        state_d   = upd ? last_d : state_q;
        press_o   = upd ? (last_d & ~state_q) : '0;
        release_o = upd ? (~last_d & state_q) : '0;
        valid_o   = strobe_i;
    end

    // Debounce registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            last_q  <= '0;
            state_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/pio_poll_master.sv
// pio_poll_master: periodic Avalon-MM poller of an input PIO feeding a debouncer
module pio_poll_master
    import pio_poll_master_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int POLL_DIV = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int INVERT = 1,
    parameter int PIO_ADDR = PIO_DATA_ADDR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [1:0]         avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [RDATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0]  btn_state,
    output logic [DATA_W-1:0]  btn_press,
    output logic [DATA_W-1:0]  btn_release,
    output logic               sample_valid
);
    localparam int TW = $clog2(POLL_DIV);

    logic [TW-1:0]     timer_q, timer_d;
    logic              pending_q, pending_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] samp_q, samp_d;
    logic              tick, go;
    logic              unused_rd;

    // Poll timer, single-deep request flag and the Avalon read FSM
    always_comb begin
        tick      = enable && (timer_q == TW'(POLL_DIV - 1));
        timer_d   = !enable ? timer_q : tick ? '0 : timer_q + TW'(1);
        go        = (state_q == ST_IDLE) && pending_q && enable;
        pending_d = (pending_q && !go) || tick;
        state_d   = (state_q == ST_IDLE) ? (go ? ST_REQ : ST_IDLE) :
                    (state_q == ST_REQ)  ? (avm_waitrequest ? ST_REQ : ST_WAIT) :
                    (state_q == ST_WAIT) ? ST_EVAL : ST_IDLE;
        samp_d    = (state_q == ST_WAIT) ? (avm_readdata[DATA_W-1:0] ^ {DATA_W{INVERT != 0}}) : samp_q;
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_IDLE;
            samp_q    <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            samp_q    <= samp_d;
        end
    end

    assign avm_address = 2'(PIO_ADDR);
    assign avm_read    = (state_q == ST_REQ);
    assign unused_rd   = ^avm_readdata;

    pio_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_i  (state_q == ST_EVAL),
        .sample_i  (samp_q),
        .state_o   (btn_state),
        .press_o   (btn_press),
        .release_o (btn_release),
        .valid_o   (sample_valid)
    );
endmodule

// File: doc/pio_poll_master.md
Name: pio_poll_master

Overview:
Avalon-MM read initiator that periodically polls a read-only input-PIO slave (readdata registered, read latency 1), e.g. the pushbutton PIO. It debounces the returned DATA_W-bit vector and emits a stable button state plus one-cycle press/release event pulses to fabric logic. This lets the buttons be consumed in hardware without a Nios II read loop.

Parameters:
DATA_W, 7, width of polled input field (readdata[DATA_W-1:0]; upper bits ignored)
POLL_DIV, 50000, clk cycles between poll ticks (min 4)
DEBOUNCE_CNT, 4, consecutive identical samples required before btn_state updates (min 1)
INVERT, 1, 1 = raw input is active-low and is inverted before debounce
PIO_ADDR, 0, word address driven on avm_address

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
enable  in  1  1 = polling active; 0 = no new transactions started
avm_address  out  2  slave address, constant PIO_ADDR
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait PIO
avm_readdata  in  32  slave read data, valid exactly 1 cycle after acceptance
btn_state  out  DATA_W  debounced, active-high button state
btn_press  out  DATA_W  1-cycle pulse per bit on 0->1 of btn_state
btn_release  out  DATA_W  1-cycle pulse per bit on 1->0 of btn_state
sample_valid  out  1  1-cycle pulse each time a sample is captured

Behaviour:
- Reset: synchronous, active-low; sampled on rising clk. Reset is decided: one clock, synchronous, active-low. Outputs after reset: avm_read=0, avm_address=PIO_ADDR, btn_state=0, btn_press=0, btn_release=0, sample_valid=0. Internal: FSM=IDLE, poll timer=0, pending=0, stable count=0, last sample=0.
- Poll timer: free-running 0..POLL_DIV-1 while enable=1. It produces a tick when it wraps to 0. It holds its value while enable=0.
- A tick sets pending. A tick arriving while pending is already set is dropped, with no queueing beyond one.
- FSM states:
  - IDLE: if pending && enable, go to REQ and clear pending.
  - REQ: avm_read=1. Hold until avm_waitrequest=0; the transfer is accepted on that edge. Then go to WAIT. avm_read must not drop while waitrequest=1.
  - WAIT: avm_read=0. On the next edge capture s = avm_readdata[DATA_W-1:0], XOR all-ones if INVERT=1. Go to EVAL.
  - EVAL: update debounce, pulse sample_valid, return to IDLE.
- enable falling during REQ/WAIT/EVAL: the transaction completes normally; no new one starts.
- Debounce, applied to the whole vector:
  - if s == last sample, stable count increments, saturating at DEBOUNCE_CNT;
  - otherwise stable count = 1 and last sample = s.
  - When stable count reaches DEBOUNCE_CNT and last sample != btn_state: btn_state <= last sample.
  - In the same cycle: btn_press = last sample & ~btn_state, and btn_release = ~last sample & btn_state.
- All pulses are exactly 1 cycle and are 0 in every other cycle.
- Latency with waitrequest=0: tick, then 4 cycles to sample_valid/btn_state update. The minimum time to a first change is DEBOUNCE_CNT polls.
- Reset asserted mid-transaction: avm_read=0 on the next edge and all state returns to reset values. A returning readdata is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/WAIT/EVAL), PIO data-register address constant 0, readdata width 32.
- One natural sub-module: pio_debounce (sample in, sample strobe in; btn_state/press/release out). The top keeps the timer and the Avalon FSM.

Test Plan:
1. Reset/idle: POLL_DIV=8, DEBOUNCE_CNT=3, INVERT=1, readdata=0x7F (all released). Run 100 cycles -> btn_state=0, no press/release pulses, sample_valid every 8 cycles, avm_read high exactly 1 cycle per poll.
2. Press: readdata changes to 0x7E -> btn_press=0x01 for 1 cycle on the 3rd consecutive sample, btn_state=0x01. Return to 0x7F -> btn_release=0x01 after 3 samples.
3. Bounce: alternate readdata 0x7E/0x7F on successive polls for 10 polls, then hold 0x7E -> no pulses during the bounce; a single btn_press=0x01 on the 3rd stable poll.
4. Waitrequest: hold avm_waitrequest=1 for 5 cycles in REQ -> avm_read stays 1 and avm_address stays 0. Capture occurs 1 cycle after waitrequest drops. A tick during the stall is serviced as one later poll.
5. Enable/reset: deassert enable -> no reads, timer frozen; re-enable -> resumes. Assert reset_n=0 in WAIT -> next cycle avm_read=0 and btn_state=0, with no sample_valid pulse.
6. Multi-bit/INVERT=0: readdata 0x05 stable for 3 polls -> btn_press=0x05. Then 0x03 stable -> btn_press=0x02, btn_release=0x04 in the same cycle.
